// File: rtl/noc_output_flow_ctrl.sv
// noc_output_flow_ctrl
// Source-side credit gate for one NoC output port. Whole CHDR packets from the
// block are held at their header until the downstream receive window (bytes
// and/or packets) has room, then passed through combinationally. Cumulative
// ACK counts arrive on the fc_* stream and are captured as absolute values.
module noc_output_flow_ctrl #(
    parameter logic [7:0] SR_FLOW_CTRL_WINDOW_SIZE = 8'd8,
    parameter logic [7:0] SR_FLOW_CTRL_PKT_LIMIT   = 8'd9,
    parameter logic [7:0] SR_FLOW_CTRL_WINDOW_EN   = 8'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    input  logic [63:0] fc_tdata,
    input  logic        fc_tlast,
    input  logic        fc_tvalid,
    output logic        fc_tready,
    output logic        stalled
);

    typedef enum logic {ST_WAIT, ST_PASS} data_state_t;
    typedef enum logic [1:0] {FC_HDR, FC_TIME, FC_PAYLOAD, FC_DROP} fc_state_t;

    logic [31:0] window_bytes_reg;
    logic [15:0] pkt_limit_reg;
    logic [1:0]  window_en_reg;

    logic [31:0] sent_bytes_reg;
    logic [31:0] sent_pkts_reg;
    logic [31:0] ack_bytes_reg;
    logic [31:0] ack_pkts_reg;

    data_state_t data_state_reg, data_state_next;
    // The first beat accepted in ST_PASS is the header that earned the credit.
    logic        hdr_pending_reg;
    fc_state_t   fc_state_reg, fc_state_next;

    logic [15:0] hdr_len;
    logic [31:0] inflight_b;
    logic [31:0] inflight_p;
    logic [32:0] need_b;
    logic [32:0] need_p;
    logic        ok_b;
    logic        ok_p;
    logic        credit_ok;
    logic        hdr_xfer;
    logic        fc_capture;
    logic        unused_bits;

    // Only the header length field steers the gate; the rest rides through.
    assign unused_bits = ^{i_tdata[63:48], i_tdata[31:0]};

    assign hdr_len    = i_tdata[47:32];
    assign inflight_b = sent_bytes_reg - ack_bytes_reg;
    assign inflight_p = sent_pkts_reg - ack_pkts_reg;

    // 33-bit sums so a large in-flight count plus a new packet cannot wrap
    // into a false "fits" result. An empty pipe always admits one packet so
    // oversize packets cannot deadlock.
    assign need_b    = {1'b0, inflight_b} + {17'd0, hdr_len};
    assign need_p    = {1'b0, inflight_p} + 33'd1;
    assign ok_b      = !window_en_reg[0] || (need_b <= {1'b0, window_bytes_reg}) || (inflight_b == 32'd0);
    assign ok_p      = !window_en_reg[1] || (need_p <= {17'd0, pkt_limit_reg}) || (inflight_p == 32'd0);
    assign credit_ok = ok_b && ok_p;

    assign hdr_xfer  = (data_state_reg == ST_PASS) && hdr_pending_reg && i_tvalid && o_tready;

    assign o_tdata   = i_tdata;
    assign o_tlast   = i_tlast;
    assign fc_tready = 1'b1;

    // Settings bus registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_bytes_reg <= 32'd0;
            pkt_limit_reg    <= 16'd0;
            window_en_reg    <= 2'd0;
        end else if (clear) begin
            window_bytes_reg <= 32'd0;
            pkt_limit_reg    <= 16'd0;
            window_en_reg    <= 2'd0;
        end else if (set_stb) begin
            if (set_addr == SR_FLOW_CTRL_WINDOW_SIZE) window_bytes_reg <= set_data;
            if (set_addr == SR_FLOW_CTRL_PKT_LIMIT)   pkt_limit_reg    <= set_data[15:0];
            if (set_addr == SR_FLOW_CTRL_WINDOW_EN)   window_en_reg    <= set_data[1:0];
        end
    end

    // Data FSM next state and handshake gating.
    always_comb begin
        data_state_next = data_state_reg;
        o_tvalid        = 1'b0;
        i_tready        = 1'b0;
        stalled         = 1'b0;
        case (data_state_reg)
            ST_WAIT: begin
                if (i_tvalid) begin
                    if (credit_ok) data_state_next = ST_PASS;
                    else           stalled         = 1'b1;
                end
            end
            ST_PASS: begin
                o_tvalid = i_tvalid;
                i_tready = o_tready;
                if (i_tvalid && o_tready && i_tlast) data_state_next = ST_WAIT;
            end
            default: data_state_next = ST_WAIT;
        endcase
    end

    // Data FSM state and sent counters, charged on the header handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_state_reg  <= ST_WAIT;
            hdr_pending_reg <= 1'b0;
            sent_bytes_reg  <= 32'd0;
            sent_pkts_reg   <= 32'd0;
        end else if (clear) begin
            data_state_reg  <= ST_WAIT;
            hdr_pending_reg <= 1'b0;
            sent_bytes_reg  <= 32'd0;
            sent_pkts_reg   <= 32'd0;
        end else begin
            data_state_reg <= data_state_next;
            if (data_state_reg == ST_WAIT && data_state_next == ST_PASS)
                hdr_pending_reg <= 1'b1;
            else if (hdr_xfer)
                hdr_pending_reg <= 1'b0;
            if (hdr_xfer) begin
                sent_bytes_reg <= sent_bytes_reg + {16'd0, hdr_len};
                sent_pkts_reg  <= sent_pkts_reg + 32'd1;
            end
        end
    end

    // FC ACK parser next state; only a well-formed FC payload word is captured.
    always_comb begin
        fc_state_next = fc_state_reg;
        fc_capture    = 1'b0;
        if (fc_tvalid) begin
            case (fc_state_reg)
                FC_HDR: begin
                    if (!fc_tlast) begin
                        if (fc_tdata[63:62] == 2'b01)
                            fc_state_next = fc_tdata[61] ? FC_TIME : FC_PAYLOAD;
                        else
                            fc_state_next = FC_DROP;
                    end
                end
                FC_TIME:    fc_state_next = fc_tlast ? FC_HDR : FC_PAYLOAD;
                FC_PAYLOAD: begin
                    fc_capture    = 1'b1;
                    fc_state_next = fc_tlast ? FC_HDR : FC_DROP;
                end
                FC_DROP:    if (fc_tlast) fc_state_next = FC_HDR;
                default:    fc_state_next = FC_HDR;
            endcase
        end
    end

    // FC parser state and absolute ACK counters (overwrite, not accumulate).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_state_reg  <= FC_HDR;
            ack_bytes_reg <= 32'd0;
            ack_pkts_reg  <= 32'd0;
        end else if (clear) begin
            fc_state_reg  <= FC_HDR;
            ack_bytes_reg <= 32'd0;
            ack_pkts_reg  <= 32'd0;
        end else begin
            fc_state_reg <= fc_state_next;
            if (fc_capture) begin
                ack_pkts_reg  <= fc_tdata[63:32];
                ack_bytes_reg <= fc_tdata[31:0];
            end
        end
    end

endmodule

// File: tb/tb_noc_output_flow_ctrl.sv
// Bench for noc_output_flow_ctrl: directed scenarios plus a randomized run,
// checked against a packet-level model of the credit window.
module tb_noc_output_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [63:0] i_tdata, o_tdata, fc_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic        o_tlast, o_tvalid, o_tready;
    logic        fc_tlast, fc_tvalid, fc_tready;
    logic        stalled;

    always #5 clk = ~clk;

    noc_output_flow_ctrl dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .fc_tdata(fc_tdata), .fc_tlast(fc_tlast), .fc_tvalid(fc_tvalid), .fc_tready(fc_tready),
        .stalled(stalled)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int pkt_no   = 0;

    // Model: settings, list of packet lengths sent, last absolute ACK seen.
    logic [31:0] m_window;
    logic [15:0] m_limit;
    logic [1:0]  m_en;
    logic [31:0] m_ack_b, m_ack_p;
    int unsigned sent_len[$];
    int          m_acked_n;

    logic [63:0] pw [0:31];
    int          pn;
    logic [63:0] fw [0:7];
    int          fn;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ok(input int unsigned len);
        logic [31:0] sb;
        logic [31:0] ib;
        logic [31:0] ip;
        bit okb, okp;
        sb = 32'd0;
        foreach (sent_len[i]) sb += sent_len[i];
        ib  = sb - m_ack_b;
        ip  = 32'(sent_len.size()) - m_ack_p;
        okb = !m_en[0] || ({32'd0, ib} + 64'(len) <= {32'd0, m_window}) || (ib == 32'd0);
        okp = !m_en[1] || ({32'd0, ip} + 64'd1 <= {48'd0, m_limit}) || (ip == 32'd0);
        return okb && okp;
    endfunction

    task automatic model_reset();
        m_window = 32'd0; m_limit = 16'd0; m_en = 2'd0;
        m_ack_b = 32'd0; m_ack_p = 32'd0;
        sent_len.delete();
        m_acked_n = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ovalid"}, o_tvalid, 1'b0);
        chk({tag, "_iready"}, i_tready, 1'b0);
        chk({tag, "_stalled"}, stalled, 1'b0);
        chk({tag, "_fcready"}, fc_tready, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = 64'd0; o_tready = 1'b1;
        fc_tvalid = 1'b0; fc_tlast = 1'b0; fc_tdata = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
        case (a)
            8'd8:    m_window = d;
            8'd9:    m_limit  = d[15:0];
            8'd10:   m_en     = d[1:0];
            default: ;
        endcase
    endtask

    task automatic build(input int nbytes);
        pn = 1 + (nbytes + 7) / 8;
        pw[0] = {2'b00, 1'b0, 13'($urandom), 16'(nbytes), 32'($urandom)};
        for (int k = 1; k < pn; k++) pw[k] = {32'($urandom), 32'($urandom)};
    endtask

    // Interpret an FC packet by the ACK rules and update the model.
    task automatic fc_model();
        int idx;
        if (fn >= 2 && fw[0][63:62] == 2'b01) begin
            idx = fw[0][61] ? 2 : 1;
            if (idx < fn) begin
                m_ack_p = fw[idx][63:32];
                m_ack_b = fw[idx][31:0];
            end
        end
    endtask

    task automatic fc_send();
        for (int k = 0; k < fn; k++) begin
            @(posedge clk); #1;
            fc_tvalid = 1'b1; fc_tdata = fw[k]; fc_tlast = (k == fn - 1);
            @(negedge clk);
            chk("fc_tready", fc_tready, 1'b1);
        end
        @(posedge clk); #1;
        fc_tvalid = 1'b0; fc_tlast = 1'b0;
        fc_model();
    endtask

    // Acknowledge the next n oldest sent packets (cumulative totals).
    task automatic ack_some(input int n, input bit has_time);
        int tgt;
        logic [31:0] b;
        tgt = m_acked_n + n;
        if (tgt > sent_len.size()) tgt = sent_len.size();
        b = 32'd0;
        for (int i = 0; i < tgt; i++) b += sent_len[i];
        fw[0] = {2'b01, has_time, 13'd0, 16'd24, 32'($urandom)};
        if (has_time) begin
            fw[1] = {32'($urandom), 32'($urandom)};
            fw[2] = {32'(tgt), b};
            fn = 3;
        end else begin
            fw[1] = {32'(tgt), b};
            fn = 2;
        end
        m_acked_n = tgt;
        fc_send();
    endtask

    task automatic run_pkt(input int nbytes, input int ack_n);
        int guard;
        build(nbytes);
        @(posedge clk); #1;
        i_tvalid = 1'b1; i_tdata = pw[0]; i_tlast = (pn == 1); o_tready = 1'b1;
        guard = 0;
        while (!model_ok(nbytes)) begin
            repeat (2) begin
                @(negedge clk);
                chk("hold_stalled", stalled, 1'b1);
                chk("hold_iready", i_tready, 1'b0);
                chk("hold_ovalid", o_tvalid, 1'b0);
            end
            ack_some((guard >= 2) ? (1 << 20) : ack_n, 1'($urandom));
            guard++;
            if (guard > 20) begin
                n_assert++; n_fail++;
                $display("FAIL credit_guard: observed %0d ack rounds required at most 20", guard);
                break;
            end
        end
        @(negedge clk);
        chk("bubble_stalled", stalled, 1'b0);
        chk("bubble_iready", i_tready, 1'b0);
        chk("bubble_ovalid", o_tvalid, 1'b0);
        @(negedge clk);
        chk("hdr_iready", i_tready, 1'b1);
        chk("hdr_ovalid", o_tvalid, 1'b1);
        chk("hdr_data", o_tdata, pw[0]);
        chk("hdr_last", o_tlast, pn == 1);
        sent_len.push_back(nbytes);
        for (int k = 1; k < pn; k++) begin
            @(posedge clk); #1;
            i_tdata = pw[k]; i_tlast = (k == pn - 1); o_tready = ($urandom % 4 != 0);
            for (int w = 0; w < 2; w++) begin
                @(negedge clk);
                chk("body_ovalid", o_tvalid, 1'b1);
                chk("body_data", o_tdata, pw[k]);
                chk("body_last", o_tlast, k == pn - 1);
                chk("body_iready", i_tready, o_tready);
                if (o_tready) break;
                @(posedge clk); #1;
                o_tready = 1'b1;
            end
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
        pkt_no++;
        $display("pkt %0d: len=%0d words=%0d ack_rounds=%0d", pkt_no, nbytes, pn, guard);
    endtask

    // Abort a packet partway through (word 2 of 4) with reset or clear.
    task automatic truncate_pkt(input bit use_clear);
        build(24);
        @(posedge clk); #1;
        i_tvalid = 1'b1; i_tdata = pw[0]; i_tlast = 1'b0; o_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("trunc_hdr", o_tdata, pw[0]);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            i_tdata = pw[k];
            if (k == 2) begin
                if (use_clear) begin
                    clear = 1'b1;
                    @(posedge clk); #1;
                    clear = 1'b0;
                    @(negedge clk);
                    check_idle_outputs("clear");
                end else begin
                    #2 reset = 1'b1;
                    #1 check_idle_outputs("async_reset");
                    @(posedge clk); #1;
                    reset = 1'b0;
                end
            end else begin
                @(negedge clk);
                chk("trunc_body", o_tdata, pw[k]);
            end
        end
        i_tvalid = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // 1. window disabled: back-to-back packets pass with one bubble each
        for (int i = 0; i < 3; i++) run_pkt(24, 1);

        // 2. byte window of 64, ACK one packet at a time
        do_reset();
        set_reg(8'd8, 32'd64);
        set_reg(8'd10, 32'd1);
        set_reg(8'd11, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) run_pkt(24, 1);

        // 3. packet limit of 2, ACK two at a time
        do_reset();
        set_reg(8'd9, 32'd2);
        set_reg(8'd10, 32'd2);
        for (int i = 0; i < 5; i++) run_pkt(24, 2);

        // 4. oversize packet waits for an empty pipe
        do_reset();
        set_reg(8'd8, 32'd64);
        set_reg(8'd10, 32'd1);
        run_pkt(24, 1 << 20);
        run_pkt(100, 1 << 20);
        run_pkt(8, 1 << 20);

        // 5. FC packets that must not update the ACK counters
        do_reset();
        set_reg(8'd8, 32'd64);
        set_reg(8'd10, 32'd1);
        run_pkt(24, 1);
        run_pkt(24, 1);
        fw[0] = {2'b00, 1'b0, 13'd0, 16'd16, 32'd0};  fw[1] = {32'd2, 32'd48}; fn = 2; fc_send();
        fw[0] = {2'b01, 1'b0, 13'd0, 16'd8, 32'd0};   fn = 1; fc_send();
        fw[0] = {2'b01, 1'b1, 13'd0, 16'd16, 32'd0};  fw[1] = {32'd2, 32'd48}; fn = 2; fc_send();
        run_pkt(24, 1);
        fw[0] = {2'b01, 1'b0, 13'd0, 16'd32, 32'd0};  fw[1] = {32'd3, 32'd72};
        fw[2] = {32'd9, 32'd9}; fw[3] = {32'd9, 32'd9}; fn = 4; fc_send();
        m_acked_n = 3;
        run_pkt(48, 1);
        run_pkt(16, 1);

        // 6. reset and clear mid-packet; settings must return to disabled
        set_reg(8'd8, 32'd16);
        set_reg(8'd9, 32'd1);
        set_reg(8'd10, 32'd3);
        run_pkt(16, 1);
        truncate_pkt(1'b0);
        for (int i = 0; i < 3; i++) run_pkt(24, 1);
        set_reg(8'd8, 32'd16);
        set_reg(8'd10, 32'd3);
        truncate_pkt(1'b1);
        for (int i = 0; i < 3; i++) run_pkt(24, 1);

        // randomized run
        do_reset();
        for (int r = 0; r < 30; r++) begin
            if ($urandom % 4 == 0) begin
                set_reg(8'd8, 32'($urandom_range(0, 160)));
                set_reg(8'd9, 32'($urandom_range(0, 4)));
                set_reg(8'd10, 32'($urandom_range(0, 3)));
            end
            if ($urandom % 5 == 0) begin
                fn = $urandom_range(1, 4);
                for (int k = 0; k < fn; k++) fw[k] = {32'($urandom), 32'($urandom)};
                fc_send();
            end
            run_pkt($urandom_range(1, 120), $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
